// File: rtl/saradc_pkg.sv
// Shared types for the SAR ADC sequencer: FSM state encoding and the
// per-bit switch levels that the CDAC rests at while idle.
package saradc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_COMPARE = 3'd4,
    ST_FINISH  = 3'd5,
    ST_BRK     = 3'd6
  } sar_state_t;

  // Idle CDAC pattern, replicated across every bit by the users.
  localparam logic IDLE_CRI = 1'b0;
  localparam logic IDLE_CRH = 1'b0;
  localparam logic IDLE_CRL = 1'b1;

endpackage

// File: rtl/saradc_sar_reg.sv
// Successive-approximation register: bit pointer, decision bits and the
// next-cycle CRH trial pattern (CRL is its complement while converting).
module saradc_sar_reg
  import saradc_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic             init_i,
  input  logic             step_i,
  input  logic             comp_i,
  output logic             last_o,
  output logic [NBITS-1:0] crh_o,
  output logic [NBITS-1:0] code_o
);

  localparam int KW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [NBITS-1:0] ONE = NBITS'(1);

  logic [KW-1:0]    k_q, k_d;
  logic [NBITS-1:0] dec_q, dec_d;

  // Pointer/decision update: init re-arms for the MSB, step records COMP at k.
  always_comb begin
    k_d   = k_q;
    dec_d = dec_q;
    if (init_i) begin
      k_d   = KW'(NBITS - 1);
      dec_d = '0;
    end else if (step_i) begin
      dec_d[k_q] = comp_i;
      if (k_q != '0) begin
        k_d = k_q - KW'(1);
      end else begin
        k_d = k_q;
      end
    end else begin
      k_d = k_q;
    end
  end

  // Pointer and decision state.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      k_q   <= KW'(NBITS - 1);
      dec_q <= '0;
    end else begin
      k_q   <= k_d;
      dec_q <= dec_d;
    end
  end

  // Decided bits plus the trial bit; undecided bits below k stay on VREFL.
  assign crh_o  = dec_d | (ONE << k_d);
  assign code_o = dec_d;
  assign last_o = (k_q == '0);

endmodule

// File: rtl/saradc_sar_ctrl.sv
// SAR ADC conversion sequencer: sample, hold, per-bit settle/compare and
// result hand-off, driving the CDAC switches and comparator strobe.
module saradc_sar_ctrl
  import saradc_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int NSAMPLE = 2,
  parameter int NSETTLE = 1
) (
  input  logic             clk_i,
  input  logic             rstb_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             comp_i,
  output logic             comp_en_o,
  output logic             vsh_o,
  output logic [NBITS-1:0] cri_o,
  output logic [NBITS-1:0] crib_o,
  output logic [NBITS-1:0] crh_o,
  output logic [NBITS-1:0] crhb_o,
  output logic [NBITS-1:0] crl_o,
  output logic [NBITS-1:0] crlb_o,
  output logic [NBITS-1:0] dout_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = 16;

  sar_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NBITS-1:0] cri_q, cri_d, crh_q, crh_d, crl_q, crl_d;
  logic [NBITS-1:0] crib_q, crhb_q, crlb_q;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             vsh_q, vsh_d, comp_en_q, comp_en_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sar_init_s, sar_step_s, sar_last_s;
  logic [NBITS-1:0] sar_crh_s, sar_code_s;

  saradc_sar_reg #(.NBITS(NBITS)) u_sar_reg (
    .clk_i  (clk_i),
    .rstb_i (rstb_i),
    .init_i (sar_init_s),
    .step_i (sar_step_s),
    .comp_i (comp_i),
    .last_o (sar_last_s),
    .crh_o  (sar_crh_s),
    .code_o (sar_code_s)
  );

  // Next-state logic; abort overrides everything outside IDLE and drops any pending decision.
  always_comb begin
    state_d    = state_q;
    sar_init_s = 1'b1;
    sar_step_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_SAMPLE;
        else         state_d = ST_IDLE;
      end
      ST_SAMPLE: begin
        if (cnt_q == CW'(NSAMPLE - 1)) state_d = ST_HOLD;
        else                           state_d = ST_SAMPLE;
      end
      ST_HOLD: state_d = ST_SETTLE;
      ST_SETTLE: begin
        sar_init_s = 1'b0;
        if (cnt_q == CW'(NSETTLE - 1)) state_d = ST_COMPARE;
        else                           state_d = ST_SETTLE;
      end
      ST_COMPARE: begin
        sar_init_s = 1'b0;
        sar_step_s = 1'b1;
        if (sar_last_s) state_d = ST_FINISH;
        else            state_d = ST_SETTLE;
      end
      ST_FINISH: begin
        if (start_i) state_d = ST_SAMPLE;
        else         state_d = ST_IDLE;
      end
      ST_BRK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d    = ST_BRK;
      sar_init_s = 1'b1;
      sar_step_s = 1'b0;
    end else begin
      sar_init_s = sar_init_s;
    end
  end

  // Output values for the state being entered, so every output is a plain register.
  always_comb begin
    cri_d     = '0;
    crh_d     = '0;
    crl_d     = '0;
    vsh_d     = 1'b0;
    comp_en_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dout_d    = dout_q;
    cnt_d     = (state_d == state_q) ? (cnt_q + CW'(1)) : '0;
    case (state_d)
      ST_IDLE: begin
        cri_d = {NBITS{IDLE_CRI}};
        crh_d = {NBITS{IDLE_CRH}};
        crl_d = {NBITS{IDLE_CRL}};
      end
      ST_SAMPLE: begin
        cri_d  = '1;
        vsh_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_HOLD: busy_d = 1'b1;
      ST_SETTLE: begin
        crh_d  = sar_crh_s;
        crl_d  = ~sar_crh_s;
        busy_d = 1'b1;
      end
      ST_COMPARE: begin
        crh_d     = sar_crh_s;
        crl_d     = ~sar_crh_s;
        comp_en_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_FINISH: begin
        done_d = 1'b1;
        dout_d = sar_code_s;
      end
      ST_BRK: busy_d = 1'b0;
      default: begin
        cri_d = {NBITS{IDLE_CRI}};
        crh_d = {NBITS{IDLE_CRH}};
        crl_d = {NBITS{IDLE_CRL}};
      end
    endcase
  end

  // FSM state, counter and all output registers.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cri_q     <= {NBITS{IDLE_CRI}};
      crh_q     <= {NBITS{IDLE_CRH}};
      crl_q     <= {NBITS{IDLE_CRL}};
      crib_q    <= ~{NBITS{IDLE_CRI}};
      crhb_q    <= ~{NBITS{IDLE_CRH}};
      crlb_q    <= ~{NBITS{IDLE_CRL}};
      vsh_q     <= 1'b0;
      comp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cri_q     <= cri_d;
      crh_q     <= crh_d;
      crl_q     <= crl_d;
      crib_q    <= ~cri_d;
      crhb_q    <= ~crh_d;
      crlb_q    <= ~crl_d;
      vsh_q     <= vsh_d;
      comp_en_q <= comp_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dout_q    <= dout_d;
    end
  end

  assign cri_o     = cri_q;
  assign crib_o    = crib_q;
  assign crh_o     = crh_q;
  assign crhb_o    = crhb_q;
  assign crl_o     = crl_q;
  assign crlb_o    = crlb_q;
  assign vsh_o     = vsh_q;
  assign comp_en_o = comp_en_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign dout_o    = dout_q;

endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// Self-checking bench for saradc_sar_ctrl: comparator model driven by an
// analog input code, scoreboard of expected conversion results.
module tb_saradc_sar_ctrl;

  localparam int NB  = 8;
  localparam int NSA = 2;
  localparam int NSE = 1;
  localparam int LAT = NSA + 1 + NB * (NSE + 1);

  logic          clk = 1'b0, rstb = 1'b0, start = 1'b0, abort = 1'b0;
  logic          comp, comp_en, vsh, busy, done;
  logic [NB-1:0] cri, crib, crh, crhb, crl, crlb, dout;
  logic [NB-1:0] vin = 8'h00;
  logic [NB-1:0] exp_q[$];

  int n_chk = 0, n_pass = 0;
  int ecount = 0;

  saradc_sar_ctrl #(.NBITS(NB), .NSAMPLE(NSA), .NSETTLE(NSE)) dut (
    .clk_i(clk), .rstb_i(rstb), .start_i(start), .abort_i(abort), .comp_i(comp),
    .comp_en_o(comp_en), .vsh_o(vsh),
    .cri_o(cri), .crib_o(crib), .crh_o(crh), .crhb_o(crhb),
    .crl_o(crl), .crlb_o(crlb), .dout_o(dout), .busy_o(busy), .done_o(done)
  );

  // Ideal comparator: keep the trial bit when the trial code does not exceed Vin.
  assign comp = (crh <= vin);

  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle monitor: switch exclusivity, complements, timing and result scoreboard.
  int   t0 = 0, nce = 0, off = 0, kk = 0;
  logic prev_busy = 1'b0, in_conv = 1'b0;
  logic [31:0] trial;
  logic [23:0] inv;
  always @(negedge clk) begin
    if (!rstb) begin
      prev_busy = 1'b0;
      in_conv   = 1'b0;
    end else begin
      check("excl", 32'((cri & crh) | (cri & crl) | (crh & crl)), 32'd0);
      inv = ~{cri, crh, crl};
      check("compl", 32'({crib, crhb, crlb}), 32'(inv));
      if (busy && !prev_busy) begin
        t0 = ecount; nce = 0; in_conv = 1'b1;
      end
      if (in_conv) begin
        off = ecount - t0;
        if (off < NSA) check("sample_sw", 32'({vsh, cri, crh, crl}), {7'd0, 1'b1, 8'hFF, 16'h0000});
        if (off == NSA) check("hold_zero", 32'({vsh, cri, crh, crl}), 32'd0);
        if (comp_en) begin
          kk    = NB - 1 - nce;
          trial = ((32'(vin) >> (kk + 1)) << (kk + 1)) | (32'd1 << kk);
          check("cen_time", off, NSA + 1 + NSE + nce * (NSE + 1));
          check("trial", 32'({crh, crl}), {16'd0, trial[7:0], ~trial[7:0]});
          nce++;
        end
        if (done) begin
          check("latency", off, LAT);
          check("n_cen", nce, NB);
          check("fin_zero", 32'({cri, crh, crl, busy}), 32'd0);
          if (exp_q.size() > 0) check("dout", 32'(dout), 32'(exp_q.pop_front()));
          else check("done_expected", 32'd0, 32'd1);
          in_conv = 1'b0;
        end else if (!busy) begin
          in_conv = 1'b0;
        end
      end else if (done) begin
        check("done_expected", 32'd0, 32'd1);
      end
      prev_busy = busy;
    end
  end

  task automatic pulse_start(input logic [NB-1:0] code, input bit expect_done);
    @(posedge clk); #1;
    start = 1'b1;
    vin   = code;
    if (expect_done) exp_q.push_back(code);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int at);
    bit seen = 1'b0;
    at = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        at   = ecount;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int d1, d2, c;
    bit hit;
    // 1: reset and idle
    #23 rstb = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_crl", 32'(crl), 32'h0FF);
    check("idle_cri_crh", 32'({cri, crh}), 32'd0);
    check("idle_flags", 32'({vsh, comp_en, busy, done}), 32'd0);
    check("idle_dout", 32'(dout), 32'd0);

    // 2: single conversion of 0xA5
    pulse_start(8'hA5, 1'b1);
    wait_done(40, d1);

    // 3: START held high, 0x00 then 0xFF back to back
    @(posedge clk); #1;
    vin = 8'h00; exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    start = 1'b1;
    wait_done(40, d1);
    vin = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, d2);
    check("b2b_period", d2 - d1, LAT + 1);
    check("b2b_dout", 32'(dout), 32'h0FF);

    // 4: abort on the 4th comparator strobe
    repeat (3) @(negedge clk);
    pulse_start(8'h3C, 1'b0);
    c = 0;
    for (int i = 0; i < 60 && c < 4; i++) begin
      @(negedge clk);
      if (comp_en) c++;
    end
    check("abort_reach", c, 4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("brk_state", 32'({cri, crh, crl, vsh, comp_en, busy, done}), 32'd0);
    @(negedge clk);
    check("brk_idle", 32'({crl, busy}), {23'd0, 8'hFF, 1'b0});
    repeat (25) @(negedge clk);
    check("abort_dout", 32'(dout), 32'h0FF);

    // 5: asynchronous reset during SETTLE, then a full conversion
    pulse_start(8'h5A, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (busy && !comp_en && crh == 8'h80) hit = 1'b1;
    end
    check("settle_reach", 32'(hit), 32'd1);
    rstb = 1'b0;
    #1;
    check("rst_crl", 32'(crl), 32'h0FF);
    check("rst_cri_crh", 32'({cri, crh}), 32'd0);
    check("rst_compl", 32'({crib, crhb, crlb}), {8'd0, 8'hFF, 8'hFF, 8'h00});
    check("rst_flags", 32'({vsh, comp_en, busy, done}), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    #2 rstb = 1'b1;
    repeat (2) @(negedge clk);
    pulse_start(8'h5A, 1'b1);
    wait_done(40, d1);
    check("post_rst_dout", 32'(dout), 32'h05A);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
